pc_redirect_unit: RTL

- Parametrised, pipelined successor to the ID-stage branch/jump target logic.
- Resolves conditional branches and jumps for the instruction in IF/ID and computes the target: PC-relative (pc+2 + imm) or register-relative (rs + imm).
- Registers the redirect, and squashes the one wrong-path fetch that follows a taken redirect using a small FSM.
- Keeps a return-address stack (RAS) for link/return instructions and reports prediction hits.

---
 rtl/pc_redirect_pkg.sv | 32 +++
 rtl/cla16.sv | 49 ++++
 rtl/pc_ras.sv | 74 +++++++
 rtl/pc_redirect_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// Shared definitions for the PC redirect slice.
//   br_type_e : branch/jump encodings carried on the br_type port
//   state_e   : squash FSM states
//   DEFAULT_* : default datapath width and return-address stack depth
// Optional feature macro used by the slice: PC_ALIGN_CHECK_EN.
package pc_redirect_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQZ = 3'b001,
    BR_BNEZ = 3'b010,
    BR_BLTZ = 3'b011,
    BR_BGEZ = 3'b100,
    BR_J    = 3'b101,
    BR_JR   = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  // The reserved encoding behaves exactly like "no branch".
  function automatic logic is_branch_or_jump(input br_type_e t);
    return (t != BR_NONE) && (t != BR_RSVD);
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups, group generate/propagate
// feed a lookahead carry chain; carry-out is discarded.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^16
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  // Bit 15's generate only feeds the discarded carry-out, so it is not formed.
  logic [14:0] g;
  logic [15:0] p;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;
  logic [15:0] c;

  assign g = a[14:0] & b[14:0];
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '1;
    grp_c = '0;
    c     = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        grp_g[k] = g[4*k+j] | (p[4*k+j] & grp_g[k]);
        grp_p[k] = grp_p[k] & p[4*k+j];
      end
    end
    grp_c[0] = cin;
    for (int k = 0; k < 3; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk, rst  : clock, asynchronous active-high reset
//   push, pop : stack operations (both together replace the top entry)
//   push_data : value pushed
//   top       : current top of stack, 0 when empty
//   empty/full: occupancy flags
// A push while full overwrites the oldest entry; a pop while empty is ignored.
module pc_ras
  import pc_redirect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_RAS_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // ptr_q points at the next free slot; cnt_q tracks occupancy so that a
  // wrapped pointer can still tell full from empty.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - PTR_ONE;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (pop && !empty) begin
      if (push) begin
        mem_d[top_idx] = push_data;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_ONE;
      if (!full) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// ID-stage branch/jump resolution with registered redirect, one-cycle
// wrong-path squash FSM and a return-address stack with hit counting.
//   clk, rst        : clock, asynchronous active-high reset
//   valid_id, stall : IF/ID valid, global pipeline stall (holds all state)
//   br_type         : branch/jump type (see pc_redirect_pkg::br_type_e)
//   is_link         : instruction pushes pc_add2 as a return address
//   is_return       : instruction pops the return-address stack
//   pc_add2, rs     : pc+2 of the instruction, forwarded rs value
//   ext_imm         : sign-extended displacement
//   redirect_valid  : registered, fetch redirect_pc next
//   redirect_pc     : registered target
//   is_bj           : registered, resolved instruction was a branch/jump
//   squash_if       : kill the instruction currently in IF/ID
//   ras_top/empty/full : return-address stack status
//   ras_hit_cnt     : saturating count of correctly predicted returns
// Optional macro PC_ALIGN_CHECK_EN adds output misalign_exc, flagging taken
// targets with bit0 set; such redirects are issued with bit0 cleared.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH,
  parameter int RAS_PTR_W = 2,
  parameter int HIT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_id,
  input  logic                 stall,
  input  logic [2:0]           br_type,
  input  logic                 is_link,
  input  logic                 is_return,
  input  logic [WIDTH-1:0]     pc_add2,
  input  logic [WIDTH-1:0]     rs,
  input  logic [WIDTH-1:0]     ext_imm,
  output logic                 redirect_valid,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic                 is_bj,
  output logic                 squash_if,
  output logic [WIDTH-1:0]     ras_top,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic [HIT_CNT_W-1:0] ras_hit_cnt
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                 misalign_exc
`endif
);

  localparam logic [HIT_CNT_W-1:0] HIT_ONE = HIT_CNT_W'(1);

  br_type_e             br;
  state_e               state_q, state_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic                 is_bj_q, is_bj_d;
  logic [HIT_CNT_W-1:0] ras_hit_cnt_q, ras_hit_cnt_d;
  logic                 taken;
  logic                 accept;
  logic                 take_redirect;
  logic [WIDTH-1:0]     add_base;
  logic [WIDTH-1:0]     target;
  logic [WIDTH-1:0]     redirect_target;
  logic                 ras_push;
  logic                 ras_pop;
`ifdef PC_ALIGN_CHECK_EN
  logic                 misalign_exc_q, misalign_exc_d;
`endif

  assign br = br_type_e'(br_type);

  always_comb begin
    taken = 1'b0;
    unique case (br)
      BR_BEQZ: taken = (rs == '0);
      BR_BNEZ: taken = (rs != '0);
      BR_BLTZ: taken = rs[WIDTH-1];
      BR_BGEZ: taken = !rs[WIDTH-1];
      BR_J,
      BR_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // One shared adder: only JR is register-relative.
  assign add_base = (br == BR_JR) ? rs : pc_add2;

  generate
    if (WIDTH == 16) begin : g_cla
      cla16 u_cla16 (
        .a   (add_base),
        .b   (ext_imm),
        .cin (1'b0),
        .sum (target)
      );
    end else begin : g_add
      assign target = add_base + ext_imm;
    end
  endgenerate

`ifdef PC_ALIGN_CHECK_EN
  assign redirect_target = {target[WIDTH-1:1], 1'b0};
`else
  assign redirect_target = target;
`endif

  // Nothing is accepted during the squash cycle: IF/ID then holds wrong-path code.
  assign accept        = valid_id && !stall && (state_q == ST_RUN);
  assign take_redirect = accept && taken;
  assign ras_push      = accept && is_link;
  assign ras_pop       = accept && is_return;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH),
    .PTR_W (RAS_PTR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_add2),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Registered outputs are one-cycle pulses; a stall freezes every register.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    is_bj_d          = is_bj_q;
    ras_hit_cnt_d    = ras_hit_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_exc_d   = misalign_exc_q;
`endif
    if (!stall) begin
      redirect_valid_d = take_redirect;
      redirect_pc_d    = take_redirect ? redirect_target : '0;
      is_bj_d          = accept && is_branch_or_jump(br);
`ifdef PC_ALIGN_CHECK_EN
      misalign_exc_d   = take_redirect && target[0];
`endif
      // ras_top still shows the entry being popped this cycle.
      if (ras_pop && !ras_empty && (ras_top == target) && (ras_hit_cnt_q != '1)) begin
        ras_hit_cnt_d = ras_hit_cnt_q + HIT_ONE;
      end
      unique case (state_q)
        ST_RUN:    state_d = take_redirect ? ST_SQUASH : ST_RUN;
        ST_SQUASH: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      is_bj_q          <= 1'b0;
      ras_hit_cnt_q    <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_exc_q   <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      is_bj_q          <= is_bj_d;
      ras_hit_cnt_q    <= ras_hit_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_exc_q   <= misalign_exc_d;
`endif
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign is_bj          = is_bj_q;
  assign squash_if      = (state_q == ST_SQUASH);
  assign ras_hit_cnt    = ras_hit_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_exc   = misalign_exc_q;
`endif

endmodule
